// File: rtl/config_regfile.sv
// Address-windowed config register file: write/read via valid->ack, change strobes, optional shadowing (CONFIG_REGFILE_SHADOW_EN).
// Latency: ack/data_out one cycle after the accepting edge; with shadowing, regs follow commit by one cycle.
// Backpressure: none; a held valid is acknowledged once, then ignored until it drops.
module config_regfile #(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 4,
  parameter int                N_REGS    = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 4'hC,
  parameter logic [DATA_W-1:0] READ_CODE = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W-1:0]        data,
  input  logic                     valid,
  input  logic                     commit,
  output logic                     ack,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_out_valid,
  output logic [N_REGS*DATA_W-1:0] regs,
  output logic [N_REGS-1:0]        reg_changed,
  output logic                     pending
);

  localparam int                RW     = N_REGS * DATA_W;
  localparam logic [ADDR_W:0]   WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0]   WIN_HI = (ADDR_W+1)'(int'(BASE_ADDR) + N_REGS);

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   req_off;
  logic [DATA_W-1:0]   req_dat;
  logic [RW-1:0]       act, act_nxt;
  logic [DATA_W-1:0]   rd_val;
  logic                in_win, is_resp, is_rd, is_wr;

  assign in_win  = ({1'b0, address} >= WIN_LO) && ({1'b0, address} < WIN_HI);
  assign is_resp = (state == ACK);
  assign is_rd   = is_resp && (req_dat == READ_CODE);
  assign is_wr   = is_resp && (req_dat != READ_CODE);
  assign regs    = act;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid && in_win) state_nxt = ACK;
      ACK:     state_nxt = valid ? HOLD : IDLE;
      HOLD:    if (!valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (req_off == ADDR_W'(i)) rd_val = act[i*DATA_W +: DATA_W];
    end
  end

`ifdef CONFIG_REGFILE_SHADOW_EN
  logic [RW-1:0] shd, shd_nxt, snap;
  logic          commit_q;

  always_comb begin
    shd_nxt = shd;
    for (int i = 0; i < N_REGS; i++) begin
      if (is_wr && req_off == ADDR_W'(i)) shd_nxt[i*DATA_W +: DATA_W] = req_dat;
    end
  end

  // snap holds the shadow as it was at the commit edge, so a coinciding write waits for the next commit
  assign act_nxt = commit_q ? snap : act;

  always_ff @(posedge clk) begin
    if (!rst) begin
      shd      <= '0;
      snap     <= '0;
      commit_q <= 1'b0;
      pending  <= 1'b0;
    end else begin
      shd      <= shd_nxt;
      commit_q <= commit;
      if (commit) snap <= shd;
      pending  <= (shd != act);
    end
  end
`else
  logic unused_commit;
  assign unused_commit = commit;
  assign pending       = 1'b0;

  always_comb begin
    act_nxt = act;
    for (int i = 0; i < N_REGS; i++) begin
      if (is_wr && req_off == ADDR_W'(i)) act_nxt[i*DATA_W +: DATA_W] = req_dat;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      req_off        <= '0;
      req_dat        <= '0;
      act            <= '0;
      ack            <= 1'b0;
      data_out_valid <= 1'b0;
      data_out       <= '0;
      reg_changed    <= '0;
    end else begin
      state <= state_nxt;
      // request fields are captured while idle and stay frozen through ACK/HOLD
      if (state == IDLE) begin
        req_off <= address - BASE_ADDR;
        req_dat <= data;
      end
      act            <= act_nxt;
      ack            <= is_resp;
      data_out_valid <= is_rd;
      data_out       <= is_rd ? rd_val : '0;
      for (int i = 0; i < N_REGS; i++) begin
        reg_changed[i] <= (act_nxt[i*DATA_W +: DATA_W] != act[i*DATA_W +: DATA_W]);
      end
    end
  end

endmodule
